// File: rtl/mem_stage_ws_if.sv
// Request/result bundle between the EX/MEM register, mem_stage_ws and write-back.
// master drives the EX/MEM request side; slave is the memory stage itself.
interface mem_stage_ws_if;
    logic        write_En;
    logic        read_En;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] DataAddress;
    logic [31:0] WriteData;
    logic [1:0]  Mem_WB;
    logic [4:0]  dest;
    logic        stall;
    logic [31:0] WB_Address;
    logic [31:0] WB_Data;
    logic [4:0]  Write_Register;
    logic [1:0]  WB;
    logic        misalign;

    modport master (
        output write_En, read_En, size, load_unsigned, DataAddress, WriteData, Mem_WB, dest,
        input  stall, WB_Address, WB_Data, Write_Register, WB, misalign
    );

    modport slave (
        input  write_En, read_En, size, load_unsigned, DataAddress, WriteData, Mem_WB, dest,
        output stall, WB_Address, WB_Data, Write_Register, WB, misalign
    );
endinterface

// File: rtl/mem_stage_ws.sv
// Data memory with byte/half/word access and WAIT_STATES extra cycles, followed by MEM/WB.
// Optional macro MEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses instead of aligning them.
module mem_stage_ws #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst,
    mem_stage_ws_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] wbAddr_q;
    logic [31:0] wbData_q;
    logic [4:0]  wbReg_q;
    logic [1:0]  wb_q;
    logic        misalign_q;

    logic          access;
    logic          isLoad;
    logic          misal;
    logic          doAccess;
    logic          stall;
    logic          complete;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [31:0]   rdWord;
    logic [7:0]    selByte;
    logic [15:0]   selHalf;
    logic [31:0]   loadData;
    logic [31:0]   storeData;
    logic [3:0]    byteEn;
    logic          unusedAddr;

    assign access     = bus.write_En | bus.read_En;
    assign isLoad     = bus.read_En & ~bus.write_En;
    assign idx        = bus.DataAddress[AW+1:2];
    assign unusedAddr = ^bus.DataAddress[31:AW+2];

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misal = 1'b0;
        if (access) begin
            if (bus.size == 2'b01)
                misal = bus.DataAddress[0];
            else if (bus.size[1])
                misal = |bus.DataAddress[1:0];
        end
    end
    assign lane = bus.DataAddress[1:0];
`else
    assign misal = 1'b0;
    always_comb begin
        lane = bus.DataAddress[1:0];
        if (bus.size == 2'b01)
            lane[0] = 1'b0;
        else if (bus.size[1])
            lane = 2'b00;
    end
`endif

    assign doAccess = access & ~misal;

    // The completing cycle of a multi-cycle access already drops stall so upstream advances on that edge.
    always_comb begin
        stall = 1'b0;
        if (WAIT_STATES != 0)
            stall = (state_q == S_IDLE) ? doAccess : (cnt_q != 4'd0);
    end

    assign complete = doAccess & ~stall;

    always_comb begin
        rdWord  = mem_q[idx];
        selByte = rdWord[{lane, 3'b000} +: 8];
        selHalf = lane[1] ? rdWord[31:16] : rdWord[15:0];
        case (bus.size)
            2'b00:   loadData = bus.load_unsigned ? {24'd0, selByte} : {{24{selByte[7]}}, selByte};
            2'b01:   loadData = bus.load_unsigned ? {16'd0, selHalf} : {{16{selHalf[15]}}, selHalf};
            default: loadData = rdWord;
        endcase
    end

    always_comb begin
        case (bus.size)
            2'b00: begin
                byteEn    = 4'b0001 << lane;
                storeData = {4{bus.WriteData[7:0]}};
            end
            2'b01: begin
                byteEn    = lane[1] ? 4'b1100 : 4'b0011;
                storeData = {2{bus.WriteData[15:0]}};
            end
            default: begin
                byteEn    = 4'b1111;
                storeData = bus.WriteData;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (complete && bus.write_En) begin
            for (int b = 0; b < 4; b++)
                if (byteEn[b])
                    mem_q[idx][8*b +: 8] <= storeData[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            wbAddr_q   <= '0;
            wbData_q   <= '0;
            wbReg_q    <= '0;
            wb_q       <= 2'b00;
            misalign_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                if (stall) begin
                    state_q <= S_WAIT;
                    cnt_q   <= CNT_INIT;
                end
            end else if (cnt_q == 4'd0) begin
                state_q <= S_IDLE;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end

            // Stalled edges inject a bubble; address and data hold their last captured values.
            if (stall) begin
                wb_q       <= 2'b00;
                wbReg_q    <= 5'd0;
                misalign_q <= 1'b0;
            end else begin
                wbAddr_q   <= bus.DataAddress;
                wbData_q   <= (complete && isLoad) ? loadData : 32'd0;
                wbReg_q    <= bus.dest;
                wb_q       <= misal ? 2'b00 : bus.Mem_WB;
                misalign_q <= misal;
            end
        end
    end

    assign bus.stall          = stall;
    assign bus.WB_Address     = wbAddr_q;
    assign bus.WB_Data        = wbData_q;
    assign bus.Write_Register = wbReg_q;
    assign bus.WB             = wb_q;
    assign bus.misalign       = misalign_q;
endmodule

// File: tb/tb_mem_stage_ws.sv
// Self-checking bench for mem_stage_ws: three instances (0, 2 and 3 wait states) share one request
// bus, only the selected one sees the access enables; results are checked against a byte-array model.
module tb_mem_stage_ws;
    localparam int DEPTH = 16;
    localparam int NB    = 4 * DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        we;
    logic        re;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mwb;
    logic [4:0]  dst;
    int          sel = 0;

    mem_stage_ws_if bus0 ();
    mem_stage_ws_if bus1 ();
    mem_stage_ws_if bus2 ();

    mem_stage_ws #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    mem_stage_ws #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mem_stage_ws #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    assign bus0.write_En = (sel == 0) && we;
    assign bus0.read_En  = (sel == 0) && re;
    assign bus1.write_En = (sel == 1) && we;
    assign bus1.read_En  = (sel == 1) && re;
    assign bus2.write_En = (sel == 2) && we;
    assign bus2.read_En  = (sel == 2) && re;

    assign bus0.size = sz;    assign bus1.size = sz;    assign bus2.size = sz;
    assign bus0.load_unsigned = uns;
    assign bus1.load_unsigned = uns;
    assign bus2.load_unsigned = uns;
    assign bus0.DataAddress = addr; assign bus1.DataAddress = addr; assign bus2.DataAddress = addr;
    assign bus0.WriteData = wdata;  assign bus1.WriteData = wdata;  assign bus2.WriteData = wdata;
    assign bus0.Mem_WB = mwb; assign bus1.Mem_WB = mwb; assign bus2.Mem_WB = mwb;
    assign bus0.dest = dst;   assign bus1.dest = dst;   assign bus2.dest = dst;

    logic        stallS;
    logic [31:0] addrS;
    logic [31:0] dataS;
    logic [4:0]  regS;
    logic [1:0]  wbS;
    logic        misS;

    always_comb begin
        stallS = bus0.stall; addrS = bus0.WB_Address; dataS = bus0.WB_Data;
        regS = bus0.Write_Register; wbS = bus0.WB; misS = bus0.misalign;
        if (sel == 1) begin
            stallS = bus1.stall; addrS = bus1.WB_Address; dataS = bus1.WB_Data;
            regS = bus1.Write_Register; wbS = bus1.WB; misS = bus1.misalign;
        end else if (sel == 2) begin
            stallS = bus2.stall; addrS = bus2.WB_Address; dataS = bus2.WB_Data;
            regS = bus2.Write_Register; wbS = bus2.WB; misS = bus2.misalign;
        end
    end

    int checks   = 0;
    int failures = 0;

    logic [7:0]  modelMem [3][NB];
    logic [31:0] prevAddr;
    logic [31:0] lastData [3];

    function automatic int wsOf(input int s);
        return (s == 0) ? 0 : (s == 1) ? 2 : 3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s (dut %0d): got 0x%08h, expected 0x%08h", name, sel, act, exp);
        end
    endtask

    task automatic idleInputs();
        we = 1'b0; re = 1'b0; sz = 2'b10; uns = 1'b0;
        addr = 32'd0; wdata = 32'd0; mwb = 2'b00; dst = 5'd0;
    endtask

    task automatic resetAll();
        idleInputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            checkOutput("rst_stall", 32'(stallS), 32'd0);
            checkOutput("rst_addr", addrS, 32'd0);
            checkOutput("rst_data", dataS, 32'd0);
            checkOutput("rst_reg", 32'(regS), 32'd0);
            checkOutput("rst_wb", 32'(wbS), 32'd0);
            checkOutput("rst_mis", 32'(misS), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < NB; i++) modelMem[s][i] = 8'h00;
            lastData[s] = 32'd0;
        end
        prevAddr = 32'd0;
    endtask

    // Called just after a rising edge; returns just after the edge that captures the result.
    task automatic applyStimulus(input int s, input logic w, input logic r, input logic [1:0] z,
                                 input logic u, input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] mw, input logic [4:0] ds);
        logic        isAcc;
        logic        isMis;
        int          n;
        int          base;
        int          ns;
        logic [31:0] expData;
        sel = s; we = w; re = r; sz = z; uns = u; addr = a; wdata = d; mwb = mw; dst = ds;
        isAcc = w | r;
        isMis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (isAcc && ((z == 2'b01 && a[0]) || (z[1] && a[1:0] != 2'b00))) isMis = 1'b1;
`endif
        n    = (z == 2'b00) ? 1 : (z == 2'b01) ? 2 : 4;
        base = int'(a[5:0]);
        base = base - (base % n);
        expData = 32'd0;
        if (r && !w && !isMis) begin
            for (int i = 0; i < n; i++) expData[8*i +: 8] = modelMem[s][base + i];
            if (!u && n == 1) expData = {{24{expData[7]}}, expData[7:0]};
            if (!u && n == 2) expData = {{16{expData[15]}}, expData[15:0]};
        end
        ns = (isAcc && !isMis) ? wsOf(s) : 0;
        for (int k = 0; k < ns; k++) begin
            @(negedge clk);
            checkOutput("stall_high", 32'(stallS), 32'd1);
            @(posedge clk);
            #1;
            checkOutput("bubble_wb", 32'(wbS), 32'd0);
            checkOutput("bubble_reg", 32'(regS), 32'd0);
            checkOutput("bubble_addr", addrS, prevAddr);
            checkOutput("bubble_data", dataS, lastData[s]);
        end
        @(negedge clk);
        checkOutput("stall_low", 32'(stallS), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("wb_addr", addrS, a);
        checkOutput("wb_data", dataS, expData);
        checkOutput("wb_reg", 32'(regS), 32'(ds));
        checkOutput("wb_ctrl", 32'(wbS), isMis ? 32'd0 : 32'(mw));
        checkOutput("wb_mis", 32'(misS), 32'(isMis));
        if (w && !isMis)
            for (int i = 0; i < n; i++) modelMem[s][base + i] = d[8*i +: 8];
        prevAddr = a;
        for (int t = 0; t < 3; t++) lastData[t] = (t == s) ? expData : 32'd0;
    endtask

    typedef struct {
        int          s;
        logic        w;
        logic        r;
        logic [1:0]  z;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  mw;
        logic [4:0]  ds;
        logic [31:0] expD;
    } vec_t;

    vec_t tbl[$];

    task automatic addVec(input int s, input logic w, input logic r, input logic [1:0] z,
                          input logic u, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] mw, input logic [4:0] ds, input logic [31:0] expD);
        vec_t v;
        v.s = s; v.w = w; v.r = r; v.z = z; v.u = u; v.a = a; v.d = d; v.mw = mw; v.ds = ds;
        v.expD = expD;
        tbl.push_back(v);
    endtask

    initial begin
        //     s  w     r     size   uns   addr     wdata         wb     dest   expected data
        addVec(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h11223344, 2'b00, 5'd0,  32'h0);
        addVec(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h22,  32'h000000AA, 2'b00, 5'd0,  32'h0);
        addVec(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20,  32'h0,        2'b01, 5'd1,  32'h11AA3344);
        addVec(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h22,  32'h0,        2'b01, 5'd2,  32'hFFFFFFAA);
        addVec(0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h22,  32'h0,        2'b01, 5'd3,  32'h000000AA);
        addVec(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h22,  32'h0,        2'b01, 5'd4,  32'h000011AA);
        addVec(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h20,  32'h0,        2'b01, 5'd5,  32'h00003344);
        addVec(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h26,  32'h00008001, 2'b00, 5'd0,  32'h0);
        addVec(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h26,  32'h0,        2'b11, 5'd6,  32'hFFFF8001);
        addVec(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h24,  32'h00000055, 2'b01, 5'd8,  32'h0);
        addVec(0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h24,  32'h0,        2'b01, 5'd9,  32'h00000055);
        addVec(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0,       2'b10, 5'd7,  32'h0);
        addVec(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h68,  32'hCAFEBABE, 2'b00, 5'd0,  32'h0);
        addVec(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h28,  32'h0,        2'b01, 5'd10, 32'hCAFEBABE);
        addVec(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30,  32'h0BADF00D, 2'b00, 5'd0,  32'h0);
        addVec(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30,  32'h0,        2'b01, 5'd11, 32'h0BADF00D);
        addVec(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h21,  32'hDEADBEEF, 2'b01, 5'd12, 32'h0);
`ifdef MEM_MISALIGN_CHECK_EN
        addVec(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20,  32'h0,        2'b01, 5'd13, 32'h11AA3344);
`else
        addVec(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20,  32'h0,        2'b01, 5'd13, 32'hDEADBEEF);
`endif

        resetAll();

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].z, tbl[i].u, tbl[i].a, tbl[i].d,
                          tbl[i].mw, tbl[i].ds);
            checkOutput("table_data", dataS, tbl[i].expD);
        end

        // Store on the 3-wait-state instance interrupted by reset while in WAIT.
        sel = 2; we = 1'b1; re = 1'b0; sz = 2'b10; uns = 1'b0;
        addr = 32'h10; wdata = 32'h12345678; mwb = 2'b01; dst = 5'd3;
        @(negedge clk);
        checkOutput("pre_rst_stall", 32'(stallS), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_bubble", 32'(wbS), 32'd0);
        resetAll();
        applyStimulus(2, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 2'b01, 5'd4);
        checkOutput("dropped_store", dataS, 32'h0);

        for (int t = 0; t < 300; t++) begin
            int          s;
            int          kind;
            logic [31:0] a;
            s    = int'($urandom_range(0, 2));
            kind = int'($urandom_range(0, 3));
            a    = $urandom;
            applyStimulus(s, kind == 1 || kind == 3, kind == 2 || kind == 3,
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
                          2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
